day_of_year_counter: RTL and testbench

- Upstream stage of the date display path. Holds the current day-of-year (1..120, or 1..121 in a leap year, covering Jan–Apr) and the leap-year flag.
- Both outputs drive the day-of-year-to-month/day converter combinationally.
- The day is stepped by debounced pushbuttons (KEY, active-low) or by an external advance tick, with wrap-around at both ends.

---
 rtl/day_of_year_counter.sv | 118 +++++++++++
 tb/tb_day_of_year_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/day_of_year_counter.sv
// Day-of-year register (Jan-Apr, 1..120 or 1..121 in a leap year) stepped by
// debounced pushbuttons or an external tick, with a registered change strobe.
module day_of_year_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 19
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_inc_n,
    input  logic       btn_dec_n,
    input  logic       leap_sw,
    input  logic       auto_en,
    input  logic       tick,
    output logic [6:0] date,
    output logic       leap_year,
    output logic       date_chg
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the increment button, index 1 the decrement button.
    logic [1:0]      btn_raw;
    logic [1:0]      btn_s1_q, btn_s2_q;
    logic [1:0]      db_q, db_d;
    logic [1:0]      armed_q, armed_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [1:0]      press;

    logic            leap_s1_q, leap_s2_q;
    logic [6:0]      date_q, date_d;
    logic            chg_q, chg_d;
    logic [6:0]      date_max;
    logic            step_up, step_down;

    assign btn_raw = {btn_dec_n, btn_inc_n};

    // A button is unarmed after reset until it has been seen released and
    // stable; the counter doubles as that stability timer while unarmed.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]    = db_q[i];
            cnt_d[i]   = cnt_q[i];
            armed_d[i] = armed_q[i];
            if (btn_s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i]  = btn_s2_q[i];
                    cnt_d[i] = '0;
                    if (btn_s2_q[i]) begin
                        armed_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!armed_q[i] && db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    armed_d[i] = 1'b1;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
            press[i] = armed_q[i] & db_q[i] & ~db_d[i];
        end
    end

    assign date_max  = leap_s2_q ? 7'd121 : 7'd120;
    assign step_up   = press[0] | (auto_en & tick);
    assign step_down = press[1];

    // A leftover day 121 after leap is cleared wins over any step request.
    always_comb begin
        date_d = date_q;
        chg_d  = 1'b0;
        if (!leap_s2_q && date_q == 7'd121) begin
            date_d = 7'd120;
            chg_d  = 1'b1;
        end else if (step_up && !step_down) begin
            date_d = (date_q == date_max) ? 7'd1 : date_q + 7'd1;
            chg_d  = 1'b1;
        end else if (step_down && !step_up) begin
            date_d = (date_q == 7'd1) ? date_max : date_q - 7'd1;
            chg_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_s1_q  <= 2'b11;
            btn_s2_q  <= 2'b11;
            db_q      <= 2'b11;
            armed_q   <= 2'b00;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            leap_s1_q <= 1'b0;
            leap_s2_q <= 1'b0;
            date_q    <= 7'd1;
            chg_q     <= 1'b0;
        end else begin
            btn_s1_q  <= btn_raw;
            btn_s2_q  <= btn_s1_q;
            db_q      <= db_d;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            leap_s1_q <= leap_sw;
            leap_s2_q <= leap_s1_q;
            date_q    <= date_d;
            chg_q     <= chg_d;
        end
    end

    assign date      = date_q;
    assign leap_year = leap_s2_q;
    assign date_chg  = chg_q;

endmodule

// File: tb/tb_day_of_year_counter.sv
// Self-checking bench for day_of_year_counter: directed scenarios followed by
// randomized operations checked against a calendar-arithmetic reference model.
module tb_day_of_year_counter;

   logic       clock;
   logic       reset_n;
   logic       btn_inc_n;
   logic       btn_dec_n;
   logic       leap_sw;
   logic       auto_en;
   logic       tick;
   logic [6:0] date;
   logic       leap_year;
   logic       date_chg;

   int compared   = 0;
   int mismatched = 0;

   int modelDate  = 1;
   int modelLeap  = 0;

   int chgCount   = 0;
   int badChg     = 0;
   int badRange   = 0;
   int opStart    = 0;
   logic [6:0] prevDate = 7'd1;
   logic       prevLeap = 1'b0;

   day_of_year_counter #(
      .DEBOUNCE_CYCLES(4),
      .DB_W(3)
   ) dut (
      .clk(clock),
      .reset_n(reset_n),
      .btn_inc_n(btn_inc_n),
      .btn_dec_n(btn_dec_n),
      .leap_sw(leap_sw),
      .auto_en(auto_en),
      .tick(tick),
      .date(date),
      .leap_year(leap_year),
      .date_chg(date_chg)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Passive monitor on the falling edge: counts change pulses, flags pulses
   // that do not change the date, and flags out-of-range dates.
   always @(negedge clock) begin
      if (reset_n) begin
         if (date_chg) begin
            chgCount++;
            if (date == prevDate) badChg++;
         end
         if (leap_year == prevLeap) begin
            if (date < 7'd1 || int'(date) > 120 + int'(leap_year)) badRange++;
         end
      end
      prevDate = date;
      prevLeap = leap_year;
   end

   // Single comparison point: counts, and reports any mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Reference calendar arithmetic.
   function automatic int modelMax();
      return 120 + modelLeap;
   endfunction

   function automatic int nextUp(input int d);
      return (d >= modelMax()) ? 1 : d + 1;
   endfunction

   function automatic int nextDown(input int d);
      return (d <= 1) ? modelMax() : d - 1;
   endfunction

   // Compare date, leap flag and pulse count since the operation started.
   task automatic checkOp(input string tag, input int expPulses);
      checkOutput({tag, "_date"}, int'(date), modelDate);
      checkOutput({tag, "_leap"}, int'(leap_year), modelLeap);
      checkOutput({tag, "_pulses"}, chgCount - opStart, expPulses);
      opStart = chgCount;
   endtask

   task automatic pressKeys(input bit inc, input bit dec, input string tag);
      opStart   = chgCount;
      btn_inc_n = !inc;
      btn_dec_n = !dec;
      waitCycles(10);
      btn_inc_n = 1'b1;
      btn_dec_n = 1'b1;
      waitCycles(12);
      if (inc && !dec) modelDate = nextUp(modelDate);
      if (dec && !inc) modelDate = nextDown(modelDate);
      checkOp(tag, (inc != dec) ? 1 : 0);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      waitCycles(3);
      reset_n = 1'b1;
      waitCycles(12);
      modelDate = 1;
      modelLeap = int'(leap_sw);
      opStart   = chgCount;
   endtask

   task automatic setLeap(input bit newLeap, input string tag);
      int pulses;
      opStart = chgCount;
      leap_sw = newLeap;
      waitCycles(6);
      pulses    = 0;
      modelLeap = int'(newLeap);
      if (modelLeap == 0 && modelDate == 121) begin
         modelDate = 120;
         pulses    = 1;
      end
      checkOp(tag, pulses);
   endtask

   task automatic sendTicks(input int n, input bit enable, input string tag);
      opStart = chgCount;
      auto_en = enable;
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         waitCycles(1);
         tick = 1'b0;
         waitCycles(2);
         if (enable) modelDate = nextUp(modelDate);
      end
      waitCycles(3);
      auto_en = 1'b0;
      checkOp(tag, enable ? n : 0);
   endtask

   // One randomized operation, chosen by op code.
   task automatic applyStimulus(input int op);
      case (op)
         0, 1:    pressKeys(1'b1, 1'b0, "rnd_inc");
         2, 3:    pressKeys(1'b0, 1'b1, "rnd_dec");
         4:       pressKeys(1'b1, 1'b1, "rnd_both");
         5:       sendTicks(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), "rnd_tick");
         default: setLeap(1'($urandom_range(0, 1)), "rnd_leap");
      endcase
   endtask

   initial begin
      bit found;
      reset_n   = 1'b0;
      btn_inc_n = 1'b1;
      btn_dec_n = 1'b1;
      leap_sw   = 1'b0;
      auto_en   = 1'b0;
      tick      = 1'b0;
      waitCycles(3);

      checkOutput("reset_date", int'(date), 1);
      checkOutput("reset_leap", int'(leap_year), 0);
      checkOutput("reset_chg", int'(date_chg), 0);
      doReset();

      $display("[TB] five clean increment presses");
      opStart = chgCount;
      for (int i = 0; i < 5; i++) begin
         btn_inc_n = 1'b0;
         waitCycles(10);
         btn_inc_n = 1'b1;
         waitCycles(10);
      end
      waitCycles(4);
      modelDate = 6;
      checkOp("five_presses", 5);

      $display("[TB] bouncing increment button");
      opStart = chgCount;
      for (int i = 0; i < 10; i++) begin
         btn_inc_n = ~btn_inc_n;
         waitCycles(2);
      end
      checkOutput("bounce_no_step", int'(date), modelDate);
      btn_inc_n = 1'b0;
      waitCycles(10);
      btn_inc_n = 1'b1;
      waitCycles(12);
      modelDate = nextUp(modelDate);
      checkOp("bounce_settled", 1);

      $display("[TB] wrap at both ends, non-leap then leap");
      pressKeys(1'b0, 1'b1, "to_start");
      while (modelDate != 120) pressKeys(1'b0, 1'b1, "walk_down");
      pressKeys(1'b1, 1'b0, "wrap_up_120");
      pressKeys(1'b0, 1'b1, "wrap_down_120");
      setLeap(1'b1, "leap_on");
      pressKeys(1'b1, 1'b0, "step_121");
      pressKeys(1'b1, 1'b0, "wrap_up_121");
      pressKeys(1'b0, 1'b1, "wrap_down_121");

      $display("[TB] leap clear clamp with coincident tick");
      opStart = chgCount;
      leap_sw = 1'b0;
      auto_en = 1'b1;
      found   = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clock);
         if (!leap_year) found = 1'b1;
      end
      checkOutput("clamp_seen", int'(found), 1);
      checkOutput("clamp_pre_date", int'(date), 121);
      tick = 1'b1;
      @(posedge clock);
      #1;
      tick = 1'b0;
      auto_en = 1'b0;
      waitCycles(4);
      modelLeap = 0;
      modelDate = 120;
      checkOp("clamp", 1);

      $display("[TB] tick-driven advance from reset");
      doReset();
      sendTicks(30, 1'b1, "ticks_on");
      checkOutput("ticks_date31", int'(date), 31);
      sendTicks(5, 1'b0, "ticks_off");

      $display("[TB] coincident presses and reset mid-debounce");
      pressKeys(1'b1, 1'b1, "both_keys");
      opStart   = chgCount;
      btn_inc_n = 1'b0;
      waitCycles(4);
      reset_n = 1'b0;
      waitCycles(3);
      reset_n = 1'b1;
      waitCycles(15);
      btn_inc_n = 1'b1;
      waitCycles(15);
      modelDate = 1;
      modelLeap = int'(leap_sw);
      checkOp("held_through_reset", 0);
      pressKeys(1'b1, 1'b0, "after_reset");

      $display("[TB] randomized operations");
      for (int i = 0; i < 60; i++) begin
         applyStimulus(int'($urandom_range(0, 6)));
      end

      checkOutput("chg_always_changes", badChg, 0);
      checkOutput("date_in_range", badRange, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
